// File: rtl/uart_cfg_shadow.sv
// Per-channel shadow of the UART baud divisor and frame format. A channel's live
// value changes only while its TX and RX are idle, or once a shared timeout expires.
module uart_cfg_shadow #(
  parameter int unsigned NumCh       = 2,
  parameter int unsigned BaudCycBits = 16,
  parameter int unsigned TimeoutBits = 20,
  parameter int unsigned BaudRst     = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NumCh-1:0]             i_tx_busy,
  input  logic [NumCh-1:0]             i_rx_busy,
  input  logic [NumCh-1:0]             i_apply,
  input  logic [NumCh-1:0]             c_auto,
  input  logic [NumCh*BaudCycBits-1:0] c_baud_cyc,
  input  logic [NumCh*5-1:0]           c_frame,
  input  logic [TimeoutBits-1:0]       c_timeout_cyc,
  output logic [NumCh*BaudCycBits-1:0] o_baud_cyc,
  output logic [NumCh*5-1:0]           o_frame,
  output logic [NumCh-1:0]             o_tx_hold,
  output logic [NumCh-1:0]             o_pending,
  output logic [NumCh-1:0]             o_upd_pulse,
  output logic [NumCh-1:0]             o_forced
);

  localparam logic [4:0]             FrameRst   = 5'b11000;
  localparam logic [BaudCycBits-1:0] BaudRstV   = BaudCycBits'(BaudRst);
  localparam logic [TimeoutBits-1:0] TimeoutOne = TimeoutBits'(1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // The timeout is shared, so its decode is computed once for all channels.
  logic                   timeout_armed;
  logic [TimeoutBits-1:0] timeout_last;

  assign timeout_armed = (c_timeout_cyc != '0);
  assign timeout_last  = c_timeout_cyc - TimeoutOne;

  genvar gi;
  generate
    for (gi = 0; gi < NumCh; gi++) begin : g_ch
      state_t                 state_reg,  state_next;
      logic [TimeoutBits-1:0] cnt_reg,    cnt_next;
      logic [BaudCycBits-1:0] baud_reg,   baud_next;
      logic [4:0]             frame_reg,  frame_next;
      logic                   upd_reg,    upd_next;
      logic                   forced_reg, forced_next;

      logic [BaudCycBits-1:0] req_baud;
      logic [4:0]             req_frame;
      logic                   differs;
      logic                   busy;
      logic                   timeout_hit;

      assign req_baud    = c_baud_cyc[gi*BaudCycBits +: BaudCycBits];
      assign req_frame   = c_frame[gi*5 +: 5];
      assign differs     = (req_baud != baud_reg) || (req_frame != frame_reg);
      assign busy        = i_tx_busy[gi] || i_rx_busy[gi];
      assign timeout_hit = timeout_armed && (cnt_reg == timeout_last);

      always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        baud_next   = baud_reg;
        frame_next  = frame_reg;
        upd_next    = 1'b0;
        forced_next = 1'b0;

        case (state_reg)
          ST_IDLE: begin
            if (c_auto[gi] ? differs : i_apply[gi]) begin
              state_next = ST_PENDING;
              cnt_next   = '0;
            end
          end

          ST_PENDING: begin
            // Cancel wins: a request that reverted needs no load and no pulse.
            if (c_auto[gi] && !differs) begin
              state_next = ST_IDLE;
            end else if (!busy || timeout_hit) begin
              state_next  = ST_IDLE;
              baud_next   = req_baud;
              frame_next  = req_frame;
              upd_next    = 1'b1;
              forced_next = busy;
            end else if (cnt_reg != '1) begin
              cnt_next = cnt_reg + TimeoutOne;
            end
          end

          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state_reg  <= ST_IDLE;
          cnt_reg    <= '0;
          baud_reg   <= BaudRstV;
          frame_reg  <= FrameRst;
          upd_reg    <= 1'b0;
          forced_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          baud_reg   <= baud_next;
          frame_reg  <= frame_next;
          upd_reg    <= upd_next;
          forced_reg <= forced_next;
        end
      end

      assign o_baud_cyc[gi*BaudCycBits +: BaudCycBits] = baud_reg;
      assign o_frame[gi*5 +: 5]                        = frame_reg;
      assign o_pending[gi]                             = (state_reg == ST_PENDING);
      assign o_tx_hold[gi]                             = (state_reg == ST_PENDING);
      assign o_upd_pulse[gi]                           = upd_reg;
      assign o_forced[gi]                              = forced_reg;
    end
  endgenerate

endmodule
